// File: rtl/box_slave_if.sv
// box_slave_if: AXI write channels (AW, W, B) plus the downstream slot
// handshake that carries one assembled burst.
interface box_slave_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MAX_BEATS = 16
);
    localparam int STRB_W = DATA_W / 8;

    // write address channel
    logic                        awvalid;
    logic                        awready;
    logic [ADDR_W-1:0]           awaddr;
    logic [7:0]                  awlen;
    logic [1:0]                  awburst;
    logic [ID_W-1:0]             awid;

    // write data channel
    logic                        wvalid;
    logic                        wready;
    logic [DATA_W-1:0]           wdata;
    logic [STRB_W-1:0]           wstrb;
    logic                        wlast;

    // write response channel
    logic                        bvalid;
    logic                        bready;
    logic [1:0]                  bresp;
    logic [ID_W-1:0]             bid;

    // downstream burst slot
    logic                        slot_valid;
    logic                        slot_ready;
    logic [ADDR_W-1:0]           slot_addr;
    logic [7:0]                  slot_len;
    logic [MAX_BEATS*DATA_W-1:0] slot_data;
    logic [MAX_BEATS*STRB_W-1:0] slot_strb;

    // the responder itself
    modport slave (
        input  awvalid, awaddr, awlen, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        output slot_valid, slot_addr, slot_len, slot_data, slot_strb,
        input  slot_ready
    );

    // the write master together with the downstream slot consumer
    modport master (
        output awvalid, awaddr, awlen, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        input  slot_valid, slot_addr, slot_len, slot_data, slot_strb,
        output slot_ready
    );
endinterface

// File: rtl/box_slave.sv
// box_slave: AXI write-side responder. Accepts one AW/W burst at a time,
// assembles the beats into a local buffer, offers the whole burst downstream
// as one slot and only then answers on B, so an OKAY means the data has been
// taken downstream.
// Optional build macro BOX_S_WLAST_CHK_EN: wlast is checked on every beat and
// an early wlast ends the burst; any wlast disagreement is reported as SLVERR.
module box_slave #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MAX_BEATS = 16
) (
    input logic        clk,
    input logic        rst_n,
    box_slave_if.slave bus
);
    localparam int         STRB_W      = DATA_W / 8;
    localparam logic [8:0] CAP         = 9'(MAX_BEATS);
    localparam logic [8:0] LAST_SLOT   = 9'(MAX_BEATS - 1);
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, DATA, PUSH, RESP} state_t;

    state_t                      state;
    state_t                      state_nx;

    logic [ADDR_W-1:0]           addr_q;
    logic [7:0]                  len_q;
    logic [ID_W-1:0]             id_q;
    logic [1:0]                  burst_q;
    logic [8:0]                  beat_cnt;   // 9 bits so awlen=255 cannot wrap
    logic                        err;
    logic [7:0]                  slot_len_q;
    logic [MAX_BEATS*DATA_W-1:0] data_q;
    logic [MAX_BEATS*STRB_W-1:0] strb_q;

    logic                        aw_hs;
    logic                        w_hs;
    logic                        count_last;
    logic                        burst_end;
    logic                        beat_err;

    assign aw_hs      = bus.awvalid && bus.awready;
    assign w_hs       = bus.wvalid && bus.wready;
    assign count_last = (beat_cnt == {1'b0, len_q});

`ifdef BOX_S_WLAST_CHK_EN
    // an early wlast closes the burst; wlast disagreeing with the count is an error
    assign burst_end = count_last || bus.wlast;
    assign beat_err  = (beat_cnt >= CAP) || (bus.wlast != count_last);
`else
    // burst length comes from awlen alone
    assign burst_end = count_last;
    assign beat_err  = (beat_cnt >= CAP);
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state decode
    always_comb begin
        // NOTE: the default assignment first keeps this block from inferring a latch.
        state_nx = state;
        unique case (state)
            IDLE: if (aw_hs) state_nx = DATA;
            DATA: if (w_hs && burst_end) state_nx = (burst_q == BURST_INCR) ? PUSH : RESP;
            PUSH: if (bus.slot_ready) state_nx = RESP;
            RESP: if (bus.bready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // handshake and response outputs decoded from the state
    always_comb begin
        bus.awready    = (state == IDLE);
        bus.wready     = (state == DATA);
        bus.slot_valid = (state == PUSH);
        bus.bvalid     = (state == RESP);
        bus.bresp      = RESP_OKAY;
        bus.bid        = '0;
        if (state == RESP) begin
            bus.bresp = err ? RESP_SLVERR : RESP_OKAY;
            bus.bid   = id_q;
        end
    end

    // slot contents come straight from registers, so they hold while PUSH waits
    assign bus.slot_addr = addr_q;
    assign bus.slot_len  = slot_len_q;
    assign bus.slot_data = data_q;
    assign bus.slot_strb = strb_q;

    // burst capture: AW fields, beat buffer, beat counter and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            len_q      <= '0;
            id_q       <= '0;
            burst_q    <= '0;
            beat_cnt   <= '0;
            err        <= 1'b0;
            slot_len_q <= '0;
            // NOTE: the beat buffer is a flop array, so it can be cleared here like any other register.
            data_q     <= '0;
            strb_q     <= '0;
        end else begin
            if (aw_hs) begin
                addr_q   <= bus.awaddr;
                len_q    <= bus.awlen;
                id_q     <= bus.awid;
                burst_q  <= bus.awburst;
                beat_cnt <= '0;
                err      <= 1'b0;
                strb_q   <= '0;
            end
            if (w_hs) begin
                // beats past the buffer match no slot and are dropped
                for (int i = 0; i < MAX_BEATS; i++) begin
                    if (beat_cnt == 9'(i)) begin
                        data_q[i*DATA_W +: DATA_W] <= bus.wdata;
                        strb_q[i*STRB_W +: STRB_W] <= bus.wstrb;
                    end
                end
                beat_cnt <= beat_cnt + 9'd1;
                if (beat_err) err <= 1'b1;
                if (burst_end) begin
                    slot_len_q <= (beat_cnt > LAST_SLOT) ? LAST_SLOT[7:0] : beat_cnt[7:0];
                    if (burst_q != BURST_INCR) err <= 1'b1;
                end
            end
        end
    end
endmodule
